commit_trace_buf: RTL and testbench
===================================

COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

Interface
REQ-001 SHALL have parameter: SIZE_ROB, default 8, number of trace entries (power of two >= 2); PW = $clog2(SIZE_ROB).
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  instruction issued into the ROB this cycle.
- issue_inst  in  32  issued instruction word.
- issue_rs1 / issue_rs2  in  5 each  source register addresses.
- issue_trap  in  1  issuer trap flag.
- flush_valid  in  1  ROB flush on mispredicted branch.
- flush_br_id  in  PW  ROB slot of the mispredicted branch.
- commit_valid  in  1  ROB head commits.
- commit_pc / commit_pc_next  in  32 each  PC of the committing instruction and its successor.
- mem_resp  in  1  data-memory response from the LSQ.
- mem_read / mem_write  in  1 each  type of the responding access.
- mem_addr / mem_rdata / mem_wdata  in  32 each  access address and data.
- mem_mbe  in  4  byte mask.
- trc_valid  out  1  trace packet valid.
- trc_order  out  64  commit sequence number.
- trc_inst  out  32; trc_trap  out  1; trc_rs1 / trc_rs2  out  5 each.
- trc_pc_rdata / trc_pc_wdata  out  32 each.
- trc_halt  out  1  self-loop commit.
- trc_mem_addr / trc_mem_rdata / trc_mem_wdata  out  32 each; trc_mem_rmask / trc_mem_wmask  out  4 each.
- full / empty  out  1 each; err  out  1  sticky overflow/underflow flag.

Function
REQ-003 SHALL store issue fields in a circular buffer of SIZE_ROB entries, using write pointer wp and read pointer rp with PW+1 bits each (wrap bit included).
REQ-004 SHALL derive full when wp and rp differ only in the wrap bit, and empty when wp == rp; both flags SHALL be combinational from the pointers.
REQ-005 SHALL write the entry at wp[PW-1:0] and increment wp when issue_valid && !full; issue_valid while full SHALL drop the entry and set err.
REQ-006 SHALL, on flush_valid, set wp so that the entry at flush_br_id becomes the newest entry (slot index flush_br_id+1 mod SIZE_ROB, wrap bit chosen so occupancy is 1..SIZE_ROB); flush SHALL override issue_valid in the same cycle.
REQ-007 SHALL, on commit_valid && !empty, register a trace packet from the entry at rp, assert trc_valid exactly one cycle later for one cycle, and increment rp.
REQ-008 SHALL ignore commit_valid while empty (trc_valid stays 0) and set err; commit and issue in the same cycle SHALL both take effect, including when full.
REQ-009 SHALL apply commit before flush in the same cycle; flush occupancy SHALL be computed against the post-commit rp.
REQ-010 SHALL latch the mem_* fields and set mem_pend on mem_resp; the next accepted commit SHALL attach them and clear mem_pend.
REQ-011 SHALL assign a mem_resp coinciding with an accepted commit to the following commit; that commit uses the previously pending data, if any.
REQ-012 SHALL drive trc_mem_rmask = mbe if read else 0, and trc_mem_wmask = mbe if write else 0; trc_mem_rdata, trc_mem_wdata and trc_mem_addr SHALL be 0 when the corresponding mask (rmask, wmask, or either) is 0.
REQ-013 SHALL drive trc_halt = 1 in a packet whose pc_rdata == pc_wdata.
REQ-014 SHALL drive trc_order at 0 for the first packet and increment it by 1 per packet, wrapping at 2^64.
REQ-015 SHALL hold all trc_* outputs stable while trc_valid = 0.

Reset
REQ-016 SHALL, on rst low and asynchronously: clear wp, rp, mem_pend, err, trc_valid and trc_order; drive all trc_* data outputs to 0; drive empty=1 and full=0. Buffer contents need not be cleared.
REQ-017 SHALL discard any in-flight commit when reset is asserted mid-operation; the first commit after release SHALL produce trc_order = 0.

Configuration
REQ-018 SHALL, with COMMIT_TRACE_PERF_EN defined, add inputs br_valid (1), br_op (1) and br_miss (1) plus outputs br_count (32) and br_miss_count (32); these SHALL increment on br_valid&&br_op and br_valid&&br_op&&br_miss respectively, saturate at all-ones, and reset to 0.
REQ-019 SHALL, without COMMIT_TRACE_PERF_EN, omit those ports and counters entirely.

Verification
REQ-020 Issue 3 (inst 0x00000013, 0x00100093, 0x00208113), commit 3 -> three trc_valid pulses, each 1 cycle after its commit, orders 0,1,2, same inst order, empty=1 afterwards.
REQ-021 SIZE_ROB=8: issue 9 without commit -> full=1 after the 8th issue, 9th dropped, err=1; then issue+commit in the same cycle -> occupancy stays 8.
REQ-022 Issue 6 (slots 0-5), flush_br_id=2 -> occupancy 3; next issue lands in slot 3; commits return slots 0,1,2,3.
REQ-023 mem_resp read addr 0x1000, mbe 0xF, rdata 0xDEADBEEF, then commit -> packet rmask=0xF, rdata=0xDEADBEEF; the next packet has rmask=0 and addr=0.
REQ-024 Commit with pc_rdata = pc_wdata = 0x60 -> trc_halt=1; commit while empty -> no packet, err=1; rst low mid-run -> trc_order restarts at 0.

Source files
------------

// File: rtl/commit_trace_buf.sv
// Commit trace buffer: captures issue fields per ROB slot and emits one trace packet per commit.
// Optional branch performance counters are enabled by defining COMMIT_TRACE_PERF_EN.
module commit_trace_buf #(
  parameter int unsigned SIZE_ROB = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [31:0]                 issue_inst,
  input  logic [4:0]                  issue_rs1,
  input  logic [4:0]                  issue_rs2,
  input  logic                        issue_trap,
  input  logic                        flush_valid,
  input  logic [$clog2(SIZE_ROB)-1:0] flush_br_id,
  input  logic                        commit_valid,
  input  logic [31:0]                 commit_pc,
  input  logic [31:0]                 commit_pc_next,
  input  logic                        mem_resp,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [31:0]                 mem_addr,
  input  logic [31:0]                 mem_rdata,
  input  logic [31:0]                 mem_wdata,
  input  logic [3:0]                  mem_mbe,
  output logic                        trc_valid,
  output logic [63:0]                 trc_order,
  output logic [31:0]                 trc_inst,
  output logic                        trc_trap,
  output logic [4:0]                  trc_rs1,
  output logic [4:0]                  trc_rs2,
  output logic [31:0]                 trc_pc_rdata,
  output logic [31:0]                 trc_pc_wdata,
  output logic                        trc_halt,
  output logic [31:0]                 trc_mem_addr,
  output logic [31:0]                 trc_mem_rdata,
  output logic [31:0]                 trc_mem_wdata,
  output logic [3:0]                  trc_mem_rmask,
  output logic [3:0]                  trc_mem_wmask,
  output logic                        full,
  output logic                        empty,
  output logic                        err
`ifdef COMMIT_TRACE_PERF_EN
  ,
  input  logic                        br_valid,
  input  logic                        br_op,
  input  logic                        br_miss,
  output logic [31:0]                 br_count,
  output logic [31:0]                 br_miss_count
`endif
);

  localparam int unsigned PW = $clog2(SIZE_ROB);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst;
    logic        trap;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic        halt;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
  } pkt_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  mbe;
  } mem_lat_t;

  logic [31:0] inst_mem [SIZE_ROB];
  logic [4:0]  rs1_mem  [SIZE_ROB];
  logic [4:0]  rs2_mem  [SIZE_ROB];
  logic        trap_mem [SIZE_ROB];

  logic [PW:0]   wp_q, wp_d, rp_q, rp_d, rp_post, flush_occ;
  logic [PW-1:0] flush_slot, flush_occ_low;
  logic          commit_acc, issue_acc;
  logic          err_q, err_d;
  logic          trc_valid_q, trc_valid_d;
  logic [63:0]   order_cnt_q, order_cnt_d;
  pkt_t          pkt_q, pkt_d;
  mem_lat_t      mem_lat_q, mem_lat_d;
  logic          mem_pend_q, mem_pend_d;
  logic [3:0]    att_rmask, att_wmask;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);

  always_comb begin
    commit_acc = commit_valid && !empty;
    // A commit frees the head slot this cycle, so a full buffer can still accept an issue.
    issue_acc  = issue_valid && !flush_valid && (!full || commit_acc);
    rp_post    = rp_q + {{PW{1'b0}}, commit_acc};
    // Occupancy after flush runs from the post-commit head through the branch slot.
    flush_slot    = flush_br_id + PW'(1);
    flush_occ_low = flush_slot - rp_post[PW-1:0];
    flush_occ     = (flush_occ_low == '0) ? (PW+1)'(SIZE_ROB) : {1'b0, flush_occ_low};
    rp_d = rp_post;
    wp_d = wp_q;
    if (flush_valid) begin
      wp_d = rp_post + flush_occ;
    end else if (issue_acc) begin
      wp_d = wp_q + {{PW{1'b0}}, 1'b1};
    end
    err_d = err_q | (issue_valid && !flush_valid && !issue_acc) | (commit_valid && empty);
  end

  always_ff @(posedge clk) begin
    if (issue_acc) begin
      inst_mem[wp_q[PW-1:0]] <= issue_inst;
      rs1_mem[wp_q[PW-1:0]]  <= issue_rs1;
      rs2_mem[wp_q[PW-1:0]]  <= issue_rs2;
      trap_mem[wp_q[PW-1:0]] <= issue_trap;
    end
  end

  always_comb begin
    att_rmask = (mem_pend_q && mem_lat_q.read)  ? mem_lat_q.mbe : 4'h0;
    att_wmask = (mem_pend_q && mem_lat_q.write) ? mem_lat_q.mbe : 4'h0;

    pkt_d       = pkt_q;
    trc_valid_d = commit_acc;
    order_cnt_d = order_cnt_q + {63'd0, commit_acc};
    if (commit_acc) begin
      pkt_d.order     = order_cnt_q;
      pkt_d.inst      = inst_mem[rp_q[PW-1:0]];
      pkt_d.trap      = trap_mem[rp_q[PW-1:0]];
      pkt_d.rs1       = rs1_mem[rp_q[PW-1:0]];
      pkt_d.rs2       = rs2_mem[rp_q[PW-1:0]];
      pkt_d.pc_rdata  = commit_pc;
      pkt_d.pc_wdata  = commit_pc_next;
      pkt_d.halt      = (commit_pc == commit_pc_next);
      pkt_d.mem_rmask = att_rmask;
      pkt_d.mem_wmask = att_wmask;
      pkt_d.mem_rdata = (att_rmask != 4'h0) ? mem_lat_q.rdata : 32'h0;
      pkt_d.mem_wdata = (att_wmask != 4'h0) ? mem_lat_q.wdata : 32'h0;
      pkt_d.mem_addr  = ((att_rmask | att_wmask) != 4'h0) ? mem_lat_q.addr : 32'h0;
    end

    // A response arriving with a commit belongs to the next commit, so it re-arms pending.
    mem_pend_d = mem_pend_q && !commit_acc;
    mem_lat_d  = mem_lat_q;
    if (mem_resp) begin
      mem_pend_d      = 1'b1;
      mem_lat_d.read  = mem_read;
      mem_lat_d.write = mem_write;
      mem_lat_d.addr  = mem_addr;
      mem_lat_d.rdata = mem_rdata;
      mem_lat_d.wdata = mem_wdata;
      mem_lat_d.mbe   = mem_mbe;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      err_q       <= 1'b0;
      trc_valid_q <= 1'b0;
      order_cnt_q <= '0;
      pkt_q       <= '0;
      mem_lat_q   <= '0;
      mem_pend_q  <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      err_q       <= err_d;
      trc_valid_q <= trc_valid_d;
      order_cnt_q <= order_cnt_d;
      pkt_q       <= pkt_d;
      mem_lat_q   <= mem_lat_d;
      mem_pend_q  <= mem_pend_d;
    end
  end

  assign err           = err_q;
  assign trc_valid     = trc_valid_q;
  assign trc_order     = pkt_q.order;
  assign trc_inst      = pkt_q.inst;
  assign trc_trap      = pkt_q.trap;
  assign trc_rs1       = pkt_q.rs1;
  assign trc_rs2       = pkt_q.rs2;
  assign trc_pc_rdata  = pkt_q.pc_rdata;
  assign trc_pc_wdata  = pkt_q.pc_wdata;
  assign trc_halt      = pkt_q.halt;
  assign trc_mem_addr  = pkt_q.mem_addr;
  assign trc_mem_rdata = pkt_q.mem_rdata;
  assign trc_mem_wdata = pkt_q.mem_wdata;
  assign trc_mem_rmask = pkt_q.mem_rmask;
  assign trc_mem_wmask = pkt_q.mem_wmask;

`ifdef COMMIT_TRACE_PERF_EN
  logic [31:0] br_count_q, br_count_d, br_miss_count_q, br_miss_count_d;

  always_comb begin
    br_count_d      = br_count_q;
    br_miss_count_d = br_miss_count_q;
    if (br_valid && br_op && (br_count_q != '1)) begin
      br_count_d = br_count_q + 32'd1;
    end
    if (br_valid && br_op && br_miss && (br_miss_count_q != '1)) begin
      br_miss_count_d = br_miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_count_q      <= '0;
      br_miss_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      br_miss_count_q <= br_miss_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign br_miss_count = br_miss_count_q;
`endif

endmodule

// File: tb/tb_commit_trace_buf.sv
// Bench for commit_trace_buf: table of issue/commit/flush vectors plus hand-written corner cases,
// with trace packets predicted by a reference queue model and checked through a scoreboard.
module tb_commit_trace_buf;

  localparam int SIZE = 8;

  logic        clk;
  logic        rst_n;
  logic        issue_valid, issue_trap, flush_valid, commit_valid;
  logic [31:0] issue_inst;
  logic [4:0]  issue_rs1, issue_rs2;
  logic [2:0]  flush_br_id;
  logic [31:0] commit_pc, commit_pc_next;
  logic        mem_resp, mem_read, mem_write;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic [3:0]  mem_mbe;
  logic        trc_valid, trc_trap, trc_halt, full, empty, err;
  logic [63:0] trc_order;
  logic [31:0] trc_inst, trc_pc_rdata, trc_pc_wdata, trc_mem_addr, trc_mem_rdata, trc_mem_wdata;
  logic [4:0]  trc_rs1, trc_rs2;
  logic [3:0]  trc_mem_rmask, trc_mem_wmask;
`ifdef COMMIT_TRACE_PERF_EN
  logic        br_valid, br_op, br_miss;
  logic [31:0] br_count, br_miss_count;
`endif

  commit_trace_buf #(.SIZE_ROB(SIZE)) dut (
    .clk(clk), .rst(rst_n),
    .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_trap(issue_trap),
    .flush_valid(flush_valid), .flush_br_id(flush_br_id),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_pc_next(commit_pc_next),
    .mem_resp(mem_resp), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_mbe(mem_mbe),
    .trc_valid(trc_valid), .trc_order(trc_order), .trc_inst(trc_inst), .trc_trap(trc_trap),
    .trc_rs1(trc_rs1), .trc_rs2(trc_rs2), .trc_pc_rdata(trc_pc_rdata),
    .trc_pc_wdata(trc_pc_wdata), .trc_halt(trc_halt), .trc_mem_addr(trc_mem_addr),
    .trc_mem_rdata(trc_mem_rdata), .trc_mem_wdata(trc_mem_wdata),
    .trc_mem_rmask(trc_mem_rmask), .trc_mem_wmask(trc_mem_wmask),
    .full(full), .empty(empty), .err(err)
`ifdef COMMIT_TRACE_PERF_EN
    , .br_valid(br_valid), .br_op(br_op), .br_miss(br_miss),
    .br_count(br_count), .br_miss_count(br_miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rb;
    bit          iv;
    logic [31:0] inst;
    bit          cv;
    bit          fv;
    logic [2:0]  fid;
    bit          ef;
    bit          ee;
    bit          eerr;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rs1, rs2;
    logic        trap;
    int          slot;
  } ent_t;

  typedef struct {
    logic [63:0] order;
    logic [31:0] inst, pcr, pcw, maddr, mrd, mwd;
    logic        trap, halt;
    logic [4:0]  rs1, rs2;
    logic [3:0]  rm, wm;
  } pkt_t;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[$];
  ent_t mq[$];
  pkt_t sb[$];
  int   m_wslot;
  logic [63:0] m_order;
  bit          m_pend, m_rd, m_wr, exp_valid;
  logic [31:0] m_addr, m_rdata, m_wdata;
  logic [3:0]  m_mbe;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(bit rb, bit iv, logic [31:0] inst, bit cv, bit fv,
                             logic [2:0] fid, bit ef, bit ee, bit eerr);
    vec_t r;
    r.rb = rb; r.iv = iv; r.inst = inst; r.cv = cv; r.fv = fv; r.fid = fid;
    r.ef = ef; r.ee = ee; r.eerr = eerr;
    return r;
  endfunction

  task automatic idle();
    issue_valid = 0; issue_inst = 0; issue_rs1 = 0; issue_rs2 = 0; issue_trap = 0;
    flush_valid = 0; flush_br_id = 0; commit_valid = 0; commit_pc = 0; commit_pc_next = 0;
    mem_resp = 0; mem_read = 0; mem_write = 0; mem_addr = 0; mem_rdata = 0; mem_wdata = 0;
    mem_mbe = 0;
`ifdef COMMIT_TRACE_PERF_EN
    br_valid = 0; br_op = 0; br_miss = 0;
`endif
  endtask

  task automatic set_issue(input logic [31:0] inst);
    issue_valid = 1; issue_inst = inst;
    issue_rs1 = inst[19:15]; issue_rs2 = inst[24:20]; issue_trap = inst[3];
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic [31:0] pcn);
    commit_valid = 1; commit_pc = pc; commit_pc_next = pcn;
  endtask

  task automatic model_update();
    ent_t e;
    pkt_t p;
    int   k;
    exp_valid = commit_valid && (mq.size() > 0);
    if (exp_valid) begin
      e = mq.pop_front();
      p.order = m_order; m_order = m_order + 1;
      p.inst = e.inst; p.rs1 = e.rs1; p.rs2 = e.rs2; p.trap = e.trap;
      p.pcr = commit_pc; p.pcw = commit_pc_next; p.halt = (commit_pc == commit_pc_next);
      p.rm = (m_pend && m_rd) ? m_mbe : 4'h0;
      p.wm = (m_pend && m_wr) ? m_mbe : 4'h0;
      p.mrd = (p.rm != 0) ? m_rdata : 32'h0;
      p.mwd = (p.wm != 0) ? m_wdata : 32'h0;
      p.maddr = (p.rm != 0 || p.wm != 0) ? m_addr : 32'h0;
      sb.push_back(p);
      m_pend = 0;
    end
    if (mem_resp) begin
      m_pend = 1; m_rd = mem_read; m_wr = mem_write; m_addr = mem_addr;
      m_rdata = mem_rdata; m_wdata = mem_wdata; m_mbe = mem_mbe;
    end
    if (flush_valid) begin
      k = -1;
      for (int j = 0; j < mq.size(); j++) if (mq[j].slot == int'(flush_br_id)) k = j;
      if (k >= 0) while (mq.size() > k + 1) void'(mq.pop_back());
      m_wslot = (int'(flush_br_id) + 1) % SIZE;
    end else if (issue_valid && mq.size() < SIZE) begin
      e.inst = issue_inst; e.rs1 = issue_rs1; e.rs2 = issue_rs2; e.trap = issue_trap;
      e.slot = m_wslot;
      mq.push_back(e);
      m_wslot = (m_wslot + 1) % SIZE;
    end
  endtask

  task automatic check_out();
    pkt_t p;
    chk("trc_valid", {63'd0, trc_valid}, {63'd0, exp_valid});
    if (trc_valid && exp_valid && sb.size() > 0) begin
      p = sb.pop_front();
      chk("trc_order", trc_order, p.order);
      chk("trc_inst", {32'd0, trc_inst}, {32'd0, p.inst});
      chk("trc_rs1_rs2_trap", {53'd0, trc_rs1, trc_rs2, trc_trap}, {53'd0, p.rs1, p.rs2, p.trap});
      chk("trc_pc", {trc_pc_rdata, trc_pc_wdata}, {p.pcr, p.pcw});
      chk("trc_halt", {63'd0, trc_halt}, {63'd0, p.halt});
      chk("trc_mem_addr", {32'd0, trc_mem_addr}, {32'd0, p.maddr});
      chk("trc_mem_data", {trc_mem_rdata, trc_mem_wdata}, {p.mrd, p.mwd});
      chk("trc_mem_masks", {56'd0, trc_mem_rmask, trc_mem_wmask}, {56'd0, p.rm, p.wm});
    end
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
    check_out();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #2;
    chk("rst_trc_valid", {63'd0, trc_valid}, 64'd0);
    chk("rst_trc_order", trc_order, 64'd0);
    chk("rst_trc_inst", {32'd0, trc_inst}, 64'd0);
    chk("rst_flags", {61'd0, empty, full, err}, {61'd0, 3'b100});
    mq.delete(); sb.delete();
    m_wslot = 0; m_order = 0; m_pend = 0; m_rd = 0; m_wr = 0;
    m_addr = 0; m_rdata = 0; m_wdata = 0; m_mbe = 0; exp_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_errors %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequence 1: three issues then three commits
    tbl.push_back(v(1, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 32'h0010_0093, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 32'h0020_8113, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0, 1, 0, 0, 0, 1, 0));
    // Sequence 2: six issues, flush at slot 2, one issue, four commits
    for (int k = 0; k < 6; k++) tbl.push_back(v(k == 0, 1, 32'hA0A0_0000 + (k << 15), 0, 0, 0,
                                                0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0, 0, 1, 3'd2, 0, 0, 0));
    tbl.push_back(v(0, 1, 32'hB0B1_8008, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 0, 32'h0, 1, 0, 0, 0, k == 3, 0));
    // Sequence 3: overflow, then issue+commit while full, then drain
    for (int k = 0; k < 8; k++) tbl.push_back(v(k == 0, 1, 32'hC000_0000 + (k << 20), 0, 0, 0,
                                                k == 7, 0, 0));
    tbl.push_back(v(0, 1, 32'hC8C8_0000, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 1, 32'hC9C9_8888, 1, 0, 0, 1, 0, 1));
    for (int k = 0; k < 8; k++) tbl.push_back(v(0, 0, 32'h0, 1, 0, 0, 0, k == 7, 1));

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_flags", {61'd0, empty, full, err}, {61'd0, 3'b100});
    chk("init_trc_valid", {63'd0, trc_valid}, 64'd0);
    chk("init_trc_order", trc_order, 64'd0);
    rst_n = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rb) do_reset();
      if (tbl[i].iv) set_issue(tbl[i].inst);
      if (tbl[i].cv) set_commit(32'h100 + 32'(i * 4), 32'h104 + 32'(i * 4));
      flush_valid = tbl[i].fv;
      flush_br_id = tbl[i].fid;
      cycle();
      chk($sformatf("row%0d_full", i), {63'd0, full}, {63'd0, tbl[i].ef});
      chk($sformatf("row%0d_empty", i), {63'd0, empty}, {63'd0, tbl[i].ee});
      chk($sformatf("row%0d_err", i), {63'd0, err}, {63'd0, tbl[i].eerr});
    end

    // Memory response attached to the next commit, then cleared
    do_reset();
    set_issue(32'h0000_1111); cycle();
    set_issue(32'h0000_2222); cycle();
    mem_resp = 1; mem_read = 1; mem_addr = 32'h1000; mem_mbe = 4'hF;
    mem_rdata = 32'hDEAD_BEEF; mem_wdata = 32'h5555_5555; cycle();
    set_commit(32'h200, 32'h204); cycle();
    chk("mem_rd_rmask", {60'd0, trc_mem_rmask}, 64'hF);
    chk("mem_rd_rdata", {32'd0, trc_mem_rdata}, 64'hDEAD_BEEF);
    chk("mem_rd_wdata", {32'd0, trc_mem_wdata}, 64'h0);
    chk("mem_rd_addr", {32'd0, trc_mem_addr}, 64'h1000);
    set_commit(32'h204, 32'h208); cycle();
    chk("mem_next_rmask", {60'd0, trc_mem_rmask}, 64'h0);
    chk("mem_next_addr", {32'd0, trc_mem_addr}, 64'h0);

    // Response coinciding with a commit belongs to the following commit
    set_issue(32'h0000_3333); cycle();
    set_issue(32'h0000_4444); cycle();
    set_commit(32'h300, 32'h304);
    mem_resp = 1; mem_write = 1; mem_addr = 32'h2000; mem_mbe = 4'h3;
    mem_wdata = 32'hCAFE_F00D; mem_rdata = 32'h7777_7777; cycle();
    chk("mem_coin_wmask", {60'd0, trc_mem_wmask}, 64'h0);
    set_commit(32'h304, 32'h308); cycle();
    chk("mem_wr_wmask", {60'd0, trc_mem_wmask}, 64'h3);
    chk("mem_wr_wdata", {32'd0, trc_mem_wdata}, 64'hCAFE_F00D);
    chk("mem_wr_rdata", {32'd0, trc_mem_rdata}, 64'h0);
    chk("mem_wr_addr", {32'd0, trc_mem_addr}, 64'h2000);

    // Halt detection, then commit while empty
    set_issue(32'h0000_006F); cycle();
    set_commit(32'h60, 32'h60); cycle();
    chk("halt_set", {63'd0, trc_halt}, 64'd1);
    set_issue(32'h0000_5555); cycle();
    set_commit(32'h64, 32'h68); cycle();
    chk("halt_clr", {63'd0, trc_halt}, 64'd0);
    chk("err_before_underflow", {63'd0, err}, 64'd0);
    set_commit(32'h68, 32'h6C); cycle();
    chk("underflow_err", {63'd0, err}, 64'd1);
    chk("hold_inst", {32'd0, trc_inst}, 64'h0000_5555);
    chk("hold_order", trc_order, 64'd5);

    // Reset during operation restarts the order count
    set_issue(32'h0000_6666); cycle();
    set_issue(32'h0000_7777); cycle();
    set_commit(32'h400, 32'h404); cycle();
    chk("pre_rst_order", trc_order, 64'd6);
    do_reset();
    set_issue(32'h0000_8888); cycle();
    set_commit(32'h500, 32'h504); cycle();
    chk("post_rst_order", trc_order, 64'd0);
    chk("post_rst_inst", {32'd0, trc_inst}, 64'h0000_8888);
    chk("post_rst_sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
